ahb_slave: RTL and testbench
============================

# ahb_slave

AHB-Lite memory slave with an internal word-organised RAM. It sits behind the AHB decoder and services single and burst transfers one beat at a time, using the master-supplied address on every beat. It supports byte, halfword and word writes and reads, wait states driven by a local ready input, and a two-cycle ERROR response for illegal transfers.

## Interface

**Parameters**
- `DEPTH`, 256: number of 32-bit words in the internal RAM.
- `IDX_W`, $clog2(DEPTH): word-index width.

**Ports**
- `hclk` in 1: clock; all logic is rising-edge.
- `hresetn` in 1: reset, synchronous, active-high; the name is kept for codebase consistency.
- `hsel` in 1: slave select.
- `hwrite` in 1: 1 = write, 0 = read.
- `hready` in 1: bus ready; an address phase is accepted only when this is 1.
- `readyin` in 1: local readiness; 0 inserts wait states.
- `haddr` in 32: address; the word index is `haddr[IDX_W+1:2]` and bits above that are ignored.
- `hwdata` in 32: write data, sampled in the data phase.
- `hsize` in 3: 000 byte, 001 halfword, 010 word; any other value is illegal.
- `hburst` in 3: accepted and ignored.
- `htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `add_offset` in 2: byte offset within the word; selects byte lanes instead of `haddr[1:0]`.
- `hrdata` out 32: read data.
- `hreadyout` out 1: transfer-complete indication.
- `hresp` out 1: 0 OKAY, 1 ERROR.

## Operation

- **Transfer accept.** A transfer is accepted at a rising edge when `hsel & hready & htrans[1]` is true. On accept, latch `hwrite`, word index, `hsize` and `add_offset`, then enter the data phase.
- **No transfer.** IDLE, BUSY or `hsel=0` produces no data phase. Outputs stay `hreadyout=1`, `hresp=0`.
- **Lane enables.**
  - Byte: lane `add_offset`.
  - Halfword: lanes {1,0} when `add_offset[1]=0`, lanes {3,2} when `add_offset[1]=1`.
  - Word: all four lanes.
- **Illegal transfer.** Any of the following gives an ERROR response and no RAM change:
  - `hsize > 3'b010`;
  - halfword with `add_offset[0]=1`;
  - word with `add_offset≠0`.
- **Write.** The enabled lanes of `mem[idx]` are loaded from the same lanes of `hwdata`. Other lanes are unchanged.
- **Read.** `hrdata` carries the enabled lanes of `mem[idx]` in their natural bit positions, with the other lanes zero.
  - Outside a read data phase, `hrdata=0`.
  - `hrdata` is combinational from the RAM and the latched control.
- **States:** IDLE, DATA, ERR1, ERR2.
  - IDLE → DATA on accept of a legal transfer.
  - IDLE → ERR1 on accept of an illegal transfer.
  - DATA → stays in DATA while `readyin=0`.
  - DATA with `readyin=1` → DATA if a new transfer is accepted on the same edge, otherwise IDLE.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → same as the completing-DATA rule.

## Timing

- **Reset.** All RAM words cleared to 0; state IDLE; `hrdata=0`, `hreadyout=1`, `hresp=0`. Reset overrides everything, including mid-data-phase; an in-flight write is discarded.
- **Zero-wait transfer.** Address phase at edge N, data phase is the cycle N→N+1.
  - `hreadyout=1` in that cycle.
  - A write commits at edge N+1.
  - Read data is valid during the cycle N→N+1.
- **Wait states.** Each data-phase cycle with `readyin=0` gives `hreadyout=0`, no commit, and `hrdata` held valid for a read. The write commits at the edge ending the first cycle with `readyin=1`. `hwdata` is sampled at that edge.
- **Pipelining.** Back-to-back transfers run every cycle. A read of a word written by the immediately preceding transfer returns the new value, because the write commits before the read's data phase starts.
- **Error response.**
  - ERR1: `hreadyout=0`, `hresp=1`.
  - ERR2: `hreadyout=1`, `hresp=1`.
  - The slave ignores `readyin` during the error response.
- **Address phase during a stall.** While `hreadyout=0`, `hready` (from the interconnect) is 0, so no new address phase is accepted.

## Test plan

- **Reset, then word write/read.** Reset, then write word `hwdata=0x00000005` at `haddr=0x0`, `add_offset=0`, NONSEQ; then read at the same address. Required: `hrdata=0x00000005`, `hresp=0`, `hreadyout=1`.
- **Wait states.** Write word `0x00000020` at `haddr=0x4` with `readyin=0` for 1 data cycle, then `readyin=1`. Required: `hreadyout=0` for one cycle and no commit until `readyin=1`; a later word read returns `0x00000020`.
- **Byte lanes.**
  - Word write `0x00000000` at `haddr=0x4`.
  - Byte writes of `hwdata=0x44667255` with `add_offset=2` and then 3.
  - Word read returns `0x44660000`.
  - Byte read with `add_offset=3` returns `0x44000000`.
  - Byte read with `add_offset=0` returns `0x00000000`.
- **Halfword.**
  - Halfword write `0x44667255` at `haddr=0x0`, `add_offset=2`.
  - Halfword read with `add_offset=2` returns `0x44660000`.
  - Halfword read with `add_offset=0` returns the prior lower half, zero-extended in place.
- **Errors.**
  - `hsize=3'b011` write at `haddr=0x0`: ERR1 (`hreadyout=0`, `hresp=1`), then ERR2 (`hreadyout=1`, `hresp=1`); RAM unchanged.
  - Same result for a halfword with `add_offset=1`.
- **Deselect/IDLE.**
  - `hsel=0` with NONSEQ and `hwdata=0x00000015`: RAM unchanged, `hreadyout=1`, `hresp=0`.
  - IDLE `htrans` behaves the same way.
  - Asserting `hresetn` mid-wait-state returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/ahb_slave.sv
// AHB-Lite memory slave: word-organised RAM, byte/half/word lanes,
// local wait states and a two-cycle ERROR response.
module ahb_slave #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic        hready,
    input  logic        readyin,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [1:0]  htrans,
    input  logic [1:0]  add_offset,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic [31:0]      mem_q [DEPTH];

    logic        accept, can_take, take, illegal, commit;
    logic [3:0]  lanes;
    logic [31:0] bmask;

    // Bits outside the word index and the burst type carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{hburst, haddr[31:IDX_W+2], haddr[1:0]};

    assign accept   = hsel & hready & htrans[1];
    assign can_take = (state_q == S_IDLE) || (state_q == S_ERR2) ||
                      ((state_q == S_DATA) && readyin);
    assign take     = accept & can_take;
    assign illegal  = (hsize > 3'b010) ||
                      ((hsize == 3'b001) && add_offset[0]) ||
                      ((hsize == 3'b010) && (add_offset != 2'b00));
    assign commit   = (state_q == S_DATA) && readyin && wr_q;

    always_comb begin
        lanes = 4'b0000;
        case (size_q)
            3'b000:  lanes = 4'b0001 << off_q;
            3'b001:  lanes = off_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            bmask[8*i +: 8] = {8{lanes[i]}};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = illegal ? S_ERR1 : S_DATA;
            S_DATA:  if (readyin) state_d = take ? (illegal ? S_ERR1 : S_DATA) : S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = take ? (illegal ? S_ERR1 : S_DATA) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (take) begin
                wr_q   <= hwrite;
                idx_q  <= haddr[IDX_W+1:2];
                size_q <= hsize;
                off_q  <= add_offset;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[idx_q] <= (mem_q[idx_q] & ~bmask) | (hwdata & bmask);
        end
    end

    assign hrdata    = ((state_q == S_DATA) && !wr_q) ? (mem_q[idx_q] & bmask) : 32'h0;
    assign hreadyout = (state_q == S_DATA) ? readyin : (state_q != S_ERR1);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_slave.sv
// Directed and randomized bench for ahb_slave against a byte-lane RAM model.
module tb_ahb_slave;

    logic        hclk = 1'b0;
    logic        hresetn, hsel, hwrite, hready, readyin;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans, add_offset;
    logic [31:0] hrdata;
    logic        hreadyout, hresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [256];

    always #5 hclk = ~hclk;

    ahb_slave dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite),
        .hready(hready), .readyin(readyin), .haddr(haddr), .hwdata(hwdata),
        .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .add_offset(add_offset), .hrdata(hrdata), .hreadyout(hreadyout),
        .hresp(hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transfer of 2**sz bytes starting at byte off; legal only if naturally aligned.
    function automatic bit is_legal(input logic [2:0] sz, input logic [1:0] off);
        int n;
        if (sz > 3'd2) return 1'b0;
        n = 1 << sz;
        return (int'(off) % n) == 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [1:0] off);
        logic [31:0] m;
        int n;
        m = '0;
        n = 1 << sz;
        for (int b = 0; b < 4; b++)
            if (b >= int'(off) && b < int'(off) + n) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hready = 1'b1;
        readyin = 1'b1; haddr = '0; hsize = 3'b010; add_offset = 2'b00;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [1:0] off, input logic [31:0] wd, input int waits,
                        input string tag);
        int idx;
        logic [31:0] m, exp_rd;
        idx = int'(addr[9:2]);
        m = lane_mask(sz, off);
        @(negedge hclk);
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; hwrite = wr;
        haddr = addr; hsize = sz; add_offset = off; readyin = 1'b1;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd; readyin = (waits == 0);
        if (!is_legal(sz, off)) begin
            @(negedge hclk);
            chk({tag, ".err1.rdy"}, {31'b0, hreadyout}, 32'd0);
            chk({tag, ".err1.resp"}, {31'b0, hresp}, 32'd1);
            @(negedge hclk);
            chk({tag, ".err2.rdy"}, {31'b0, hreadyout}, 32'd1);
            chk({tag, ".err2.resp"}, {31'b0, hresp}, 32'd1);
            readyin = 1'b1;
            return;
        end
        exp_rd = wr ? 32'h0 : (model[idx] & m);
        for (int w = 0; w < waits; w++) begin
            @(negedge hclk);
            chk({tag, ".wait.rdy"}, {31'b0, hreadyout}, 32'd0);
            chk({tag, ".wait.rd"}, hrdata, exp_rd);
            @(posedge hclk);
            #1;
            readyin = (w == waits - 1);
        end
        @(negedge hclk);
        chk({tag, ".rdy"}, {31'b0, hreadyout}, 32'd1);
        chk({tag, ".resp"}, {31'b0, hresp}, 32'd0);
        chk({tag, ".rd"}, hrdata, exp_rd);
        if (wr) model[idx] = (model[idx] & ~m) | (wd & m);
    endtask

    initial begin
        logic [31:0] r, a, hold;
        idle_bus();
        hburst = 3'b000; hwdata = '0; hresetn = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("reset.rd", hrdata, 32'h0);
        chk("reset.rdy", {31'b0, hreadyout}, 32'd1);
        chk("reset.resp", {31'b0, hresp}, 32'd0);
        hresetn = 1'b0;

        xfer(1, 32'h0, 3'b010, 2'd0, 32'h0000_0005, 0, "w0");
        xfer(0, 32'h0, 3'b010, 2'd0, 32'h0, 0, "r0");
        chk("r0.val", model[0], 32'h0000_0005);

        xfer(1, 32'h4, 3'b010, 2'd0, 32'h0000_0020, 1, "wwait");
        xfer(0, 32'h4, 3'b010, 2'd0, 32'h0, 0, "rwait");

        xfer(1, 32'h4, 3'b010, 2'd0, 32'h0, 0, "wclr");
        xfer(1, 32'h4, 3'b000, 2'd2, 32'h4466_7255, 0, "wb2");
        xfer(1, 32'h4, 3'b000, 2'd3, 32'h4466_7255, 0, "wb3");
        xfer(0, 32'h4, 3'b010, 2'd0, 32'h0, 0, "rbw");
        chk("rbw.model", model[1], 32'h4466_0000);
        xfer(0, 32'h4, 3'b000, 2'd3, 32'h0, 0, "rb3");
        xfer(0, 32'h4, 3'b000, 2'd0, 32'h0, 0, "rb0");

        xfer(1, 32'h0, 3'b001, 2'd2, 32'h4466_7255, 0, "wh2");
        xfer(0, 32'h0, 3'b001, 2'd2, 32'h0, 0, "rh2");
        xfer(0, 32'h0, 3'b001, 2'd0, 32'h0, 2, "rh0");

        xfer(1, 32'h0, 3'b011, 2'd0, 32'hDEAD_BEEF, 0, "esz");
        xfer(1, 32'h0, 3'b001, 2'd1, 32'hDEAD_BEEF, 0, "eoff");
        xfer(0, 32'h0, 3'b010, 2'd0, 32'h0, 0, "rerr");

        // deselected and IDLE address phases must not touch the RAM
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'b010;
        @(posedge hclk);
        #1 hwdata = 32'h0000_0015; hsel = 1'b1; htrans = 2'b00; haddr = 32'h4;
        @(negedge hclk);
        chk("desel.rdy", {31'b0, hreadyout}, 32'd1);
        chk("desel.resp", {31'b0, hresp}, 32'd0);
        @(posedge hclk);
        #1;
        @(negedge hclk);
        chk("idle.rdy", {31'b0, hreadyout}, 32'd1);
        chk("idle.rd", hrdata, 32'h0);
        idle_bus();
        xfer(0, 32'h0, 3'b010, 2'd0, 32'h0, 0, "rdesel");
        xfer(0, 32'h4, 3'b010, 2'd0, 32'h0, 0, "ridle");

        // pipelined write then read of the same word
        @(negedge hclk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h14; hsize = 3'b010;
        @(posedge hclk);
        #1 hwdata = 32'hCAFE_F00D; hwrite = 1'b0;
        @(negedge hclk);
        chk("pipe.wrdy", {31'b0, hreadyout}, 32'd1);
        @(posedge hclk);
        #1 idle_bus();
        model[5] = 32'hCAFE_F00D;
        @(negedge hclk);
        chk("pipe.rd", hrdata, 32'hCAFE_F00D);

        for (int n = 0; n < 200; n++) begin
            r = $urandom();
            a = {r[31:10], 5'b0, r[4:2], r[1:0]};
            hold = $urandom();
            xfer(r[5], a, (r[9:6] < 4'd13) ? 3'(r[7:6] % 3) : r[8:6],
                 r[11:10], hold, int'(r[13:12] % 3), "rand");
        end

        // reset asserted in the middle of a wait-stated write
        @(negedge hclk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'b010;
        @(posedge hclk);
        #1 idle_bus(); readyin = 1'b0; hwdata = 32'h1234_5678;
        @(negedge hclk);
        chk("rstmid.wait", {31'b0, hreadyout}, 32'd0);
        hresetn = 1'b1; readyin = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        @(negedge hclk);
        chk("rstmid.rdy", {31'b0, hreadyout}, 32'd1);
        chk("rstmid.resp", {31'b0, hresp}, 32'd0);
        chk("rstmid.rd", hrdata, 32'h0);
        hresetn = 1'b0;
        xfer(0, 32'h8, 3'b010, 2'd0, 32'h0, 0, "rstmid.r8");
        xfer(0, 32'h14, 3'b010, 2'd0, 32'h0, 0, "rstmid.r14");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
